// File: rtl/alu_result_buffer_if.sv
// Bus bundle for alu_result_buffer: unit results and flags, FIFO head
// handshake, status and error bits.
// When ALU_RESBUF_PARITY_EN is defined the bundle also carries res_parity.
interface alu_result_buffer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [2*WIDTH-1:0] arith_out;
  logic               arith_flag;
  logic [2*WIDTH-1:0] logic_out;
  logic               logic_flag;
  logic [2*WIDTH-1:0] cmp_out;
  logic               cmp_flag;
  logic [2*WIDTH-1:0] shift_out;
  logic               shift_flag;
  logic [2*WIDTH-1:0] res_data;
  logic [1:0]         res_tag;
  logic               res_valid;
  logic               res_ready;
  logic [PTR_W:0]     fifo_count;
  logic               overflow_err;
  logic               collision_err;
  logic               clr_err;
`ifdef ALU_RESBUF_PARITY_EN
  logic               res_parity;

  modport master (
    output arith_out, arith_flag, logic_out, logic_flag,
    output cmp_out, cmp_flag, shift_out, shift_flag,
    output res_ready, clr_err,
    input  res_data, res_tag, res_valid, fifo_count,
    input  overflow_err, collision_err, res_parity
  );

  modport slave (
    input  arith_out, arith_flag, logic_out, logic_flag,
    input  cmp_out, cmp_flag, shift_out, shift_flag,
    input  res_ready, clr_err,
    output res_data, res_tag, res_valid, fifo_count,
    output overflow_err, collision_err, res_parity
  );
`else
  modport master (
    output arith_out, arith_flag, logic_out, logic_flag,
    output cmp_out, cmp_flag, shift_out, shift_flag,
    output res_ready, clr_err,
    input  res_data, res_tag, res_valid, fifo_count,
    input  overflow_err, collision_err
  );

  modport slave (
    input  arith_out, arith_flag, logic_out, logic_flag,
    input  cmp_out, cmp_flag, shift_out, shift_flag,
    input  res_ready, clr_err,
    output res_data, res_tag, res_valid, fifo_count,
    output overflow_err, collision_err
  );
`endif
endinterface

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: aligns each ALU unit's early done flag with its
// registered result, tags the highest-priority result with its source unit
// and queues it in a DEPTH-entry FIFO drained over valid/ready.
// Optional feature macro: ALU_RESBUF_PARITY_EN (per-entry parity, res_parity).
module alu_result_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rest,
  alu_result_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int DW    = 2 * WIDTH;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Flag vector order is {arith, logic, cmp, shift}; arith has top priority.
  function automatic logic [1:0] pick_tag(input logic [3:0] f);
    if (f[3])      return 2'b00;
    else if (f[2]) return 2'b01;
    else if (f[1]) return 2'b10;
    else           return 2'b11;
  endfunction

  function automatic logic multi_hot(input logic [3:0] f);
    return (f & (f - 4'd1)) != 4'd0;
  endfunction

  logic [3:0]       flag_p1;
  logic             vld_p1;
  logic [1:0]       tag_p1;
  logic [DW-1:0]    data_p1;

  logic [DW-1:0]    data_mem [DEPTH];
  logic [1:0]       tag_mem  [DEPTH];
`ifdef ALU_RESBUF_PARITY_EN
  logic             par_mem  [DEPTH];
`endif
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             ovf_err;
  logic             col_err;

  logic             empty;
  logic             full;
  logic             pop;
  logic             accept;
  logic             drop;
  logic             collide;

  // Select the winning result and derive push/pop/drop decisions.
  always_comb begin
    vld_p1  = |flag_p1;
    tag_p1  = pick_tag(flag_p1);
    collide = multi_hot(flag_p1);
    case (tag_p1)
      2'b00:   data_p1 = bus.arith_out;
      2'b01:   data_p1 = bus.logic_out;
      2'b10:   data_p1 = bus.cmp_out;
      default: data_p1 = bus.shift_out;
    endcase
    empty  = (count == '0);
    full   = (count == FULL_CNT);
    pop    = !empty && bus.res_ready;
    accept = vld_p1 && (!full || pop);
    drop   = vld_p1 && full && !pop;
  end

  // Stage p0 -> p1: delay the combinational flags to line up with *_out.
  always_ff @(posedge clk) begin
    if (!rest) flag_p1 <= '0;
    else       flag_p1 <= {bus.arith_flag, bus.logic_flag, bus.cmp_flag, bus.shift_flag};
  end

  // Stage p1 -> FIFO: entry storage; stale contents are masked by count.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_mem[wr_ptr] <= data_p1;
      tag_mem[wr_ptr]  <= tag_p1;
`ifdef ALU_RESBUF_PARITY_EN
      par_mem[wr_ptr]  <= ^data_p1;
`endif
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (!rest) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky errors: a new event in the same cycle as clr_err keeps the bit set.
  always_ff @(posedge clk) begin
    if (!rest) begin
      ovf_err <= 1'b0;
      col_err <= 1'b0;
    end else begin
      ovf_err <= drop    || (ovf_err && !bus.clr_err);
      col_err <= collide || (col_err && !bus.clr_err);
    end
  end

  assign bus.res_valid     = !empty;
  assign bus.res_data      = empty ? '0 : data_mem[rd_ptr];
  assign bus.res_tag       = empty ? 2'b00 : tag_mem[rd_ptr];
  assign bus.fifo_count    = count;
  assign bus.overflow_err  = ovf_err;
  assign bus.collision_err = col_err;
`ifdef ALU_RESBUF_PARITY_EN
  assign bus.res_parity    = empty ? 1'b0 : par_mem[rd_ptr];
`endif
endmodule
